// File: rtl/sw_debounce_pkg.sv
// Shared types and defaults for the sw_debounce switch conditioner.
package sw_debounce_pkg;

  typedef enum logic [0:0] {
    STABLE = 1'b0,
    SETTLE = 1'b1
  } sw_db_state_t;

  localparam int unsigned SW_DB_DEFAULT_CYCLES = 32'd500000;
  localparam int unsigned SW_DB_DEFAULT_LONG   = 32'd50000000;

  // True when a switch level differs from the unpressed level.
  function automatic logic is_pressed(input logic lvl, input logic idle_lvl);
    return (lvl != idle_lvl);
  endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer with a configurable reset value.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic s0_q;
  logic s1_q;

  // Two-stage metastability filter, synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s0_q <= RST_VAL;
      s1_q <= RST_VAL;
    end else begin
      s0_q <= d_i;
      s1_q <= s0_q;
    end
  end

  assign q_o = s1_q;

endmodule

// File: rtl/sw_debounce.sv
// Debounces one raw switch into a clean level plus press/release strobes.
// Optional long-press strobe is built only when SW_DEBOUNCE_LONGPRESS_EN is defined.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = SW_DB_DEFAULT_CYCLES,
  parameter logic        IDLE_LVL        = 1'b1,
  parameter int unsigned LONG_CYCLES     = SW_DB_DEFAULT_LONG
) (
  input  logic sysclk,
  input  logic rst,
  input  logic sw_i,
  output logic sw_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 32'd1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

  if (DEBOUNCE_CYCLES < 32'd1) begin : g_bad_cycles
    $error("sw_debounce: DEBOUNCE_CYCLES must be >= 1");
  end
  if (LONG_CYCLES < 32'd1) begin : g_bad_long
    $error("sw_debounce: LONG_CYCLES must be >= 1");
  end

  logic             sw_s;
  logic             settle_done_s;
  sw_db_state_t     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sw_q;
  logic             press_q;
  logic             release_q;

  sync2 #(
    .RST_VAL (IDLE_LVL)
  ) u_sync (
    .clk_i (sysclk),
    .rst_i (rst),
    .d_i   (sw_i),
    .q_o   (sw_s)
  );

  // The new level has been held long enough to be accepted on this edge.
  assign settle_done_s = (state_q == SETTLE) && (sw_s != sw_q) && (cnt_q == CNT_LAST);

  // Debounce FSM with registered level and strobes.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q   <= STABLE;
      cnt_q     <= {CNT_W{1'b0}};
      sw_q      <= IDLE_LVL;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        STABLE: begin
          if (sw_s != sw_q) begin
            state_q <= SETTLE;
            cnt_q   <= {CNT_W{1'b0}};
          end else begin
            state_q <= STABLE;
          end
        end
        SETTLE: begin
          if (sw_s == sw_q) begin
            state_q <= STABLE;
          end else if (settle_done_s) begin
            sw_q      <= sw_s;
            press_q   <= is_pressed(sw_s, IDLE_LVL);
            release_q <= ~is_pressed(sw_s, IDLE_LVL);
            state_q   <= STABLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= STABLE;
          cnt_q   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign sw_o      = sw_q;
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef SW_DEBOUNCE_LONGPRESS_EN
  localparam int unsigned LONG_W = $clog2(LONG_CYCLES + 32'd1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 32'd1);
  localparam logic [LONG_W-1:0] LONG_SAT  = LONG_W'(LONG_CYCLES);

  logic              release_evt_s;
  logic [LONG_W-1:0] long_cnt_d;
  logic [LONG_W-1:0] long_cnt_q;
  logic              long_d;
  logic              long_q;

  assign release_evt_s = settle_done_s && ~is_pressed(sw_s, IDLE_LVL);

  // Held-press counter: zero while idle, saturates one past the firing point
  // so the strobe cannot repeat; a release on the firing edge wins.
  always_comb begin
    long_cnt_d = long_cnt_q;
    long_d     = 1'b0;
    if (!is_pressed(sw_q, IDLE_LVL)) begin
      long_cnt_d = {LONG_W{1'b0}};
    end else if (release_evt_s) begin
      long_cnt_d = {LONG_W{1'b0}};
    end else begin
      long_d = (long_cnt_q == LONG_LAST);
      if (long_cnt_q != LONG_SAT) begin
        long_cnt_d = long_cnt_q + LONG_W'(1);
      end else begin
        long_cnt_d = long_cnt_q;
      end
    end
  end

  // Long-press counter and strobe registers.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      long_cnt_q <= {LONG_W{1'b0}};
      long_q     <= 1'b0;
    end else begin
      long_cnt_q <= long_cnt_d;
      long_q     <= long_d;
    end
  end

  assign long_o = long_q;
`else
  assign long_o = 1'b0;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce: segment table, timed corner cases and random stimulus.
module tb_sw_debounce;

  localparam int DC = 4;
  localparam int LC = 16;
`ifdef SW_DEBOUNCE_LONGPRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic sysclk = 1'b0;
  logic rst;
  logic sw_i;
  logic sw_o, press_o, release_o, long_o;

  int checks = 0;
  int errors = 0;

  // Behavioural model: synchronizer pipe, run length of disagreement, cycles held pressed.
  logic ms0, ms1, mo, ep, er, el;
  int   run;
  int   since;
  int   n_press, n_rel, n_long;

  typedef struct {
    logic rst;
    logic sw;
    int   cycles;
    logic exp_sw_o;
    int   exp_press;
    int   exp_rel;
    int   exp_long;
  } seg_t;

  seg_t segs[10];

  always #5 sysclk = ~sysclk;

  sw_debounce #(
    .DEBOUNCE_CYCLES (DC),
    .IDLE_LVL        (1'b1),
    .LONG_CYCLES     (LC)
  ) dut (
    .sysclk    (sysclk),
    .rst       (rst),
    .sw_i      (sw_i),
    .sw_o      (sw_o),
    .press_o   (press_o),
    .release_o (release_o),
    .long_o    (long_o)
  );

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge: advance the model from pre-edge inputs, then compare.
  task automatic step();
    logic in_v, rst_v, old_mo;
    in_v  = sw_i;
    rst_v = rst;
    @(posedge sysclk);
    ep = 1'b0; er = 1'b0; el = 1'b0;
    if (rst_v) begin
      ms0 = 1'b1; ms1 = 1'b1; mo = 1'b1; run = 0; since = -1;
    end else begin
      old_mo = mo;
      run = (ms1 != mo) ? run + 1 : 0;
      if (run == DC + 1) begin
        mo  = ms1;
        run = 0;
        ep  = (mo == 1'b0);
        er  = (mo == 1'b1);
      end
      if (ep) since = 0;
      else if (er) since = -1;
      else if (old_mo == 1'b0 && since >= 0) begin
        since++;
        el = LONG_EN && (since == LC);
      end
      ms1 = ms0;
      ms0 = in_v;
    end
    #1;
    check("model_sw_o", sw_o, mo);
    check("model_press", press_o, ep);
    check("model_release", release_o, er);
    check("model_long", long_o, el);
    n_press += int'(press_o === 1'b1);
    n_rel   += int'(release_o === 1'b1);
    n_long  += int'(long_o === 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1; sw_i = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    int first_long;
    rst = 1'b1;
    sw_i = 1'b1;
    ms0 = 1'b1; ms1 = 1'b1; mo = 1'b1; run = 0; since = -1;
    n_press = 0; n_rel = 0; n_long = 0;

    segs[0] = '{1'b1, 1'b1,  3, 1'b1, 0, 0, 0};
    segs[1] = '{1'b0, 1'b1, 20, 1'b1, 0, 0, 0};
    segs[2] = '{1'b0, 1'b0, 10, 1'b0, 1, 0, 0};
    segs[3] = '{1'b0, 1'b1, 10, 1'b1, 0, 1, 0};
    segs[4] = '{1'b0, 1'b0,  3, 1'b1, 0, 0, 0};
    segs[5] = '{1'b0, 1'b1,  2, 1'b1, 0, 0, 0};
    segs[6] = '{1'b0, 1'b0,  2, 1'b1, 0, 0, 0};
    segs[7] = '{1'b0, 1'b1, 12, 1'b1, 0, 0, 0};
    segs[8] = '{1'b0, 1'b0, 46, 1'b0, 1, 0, (LONG_EN ? 1 : 0)};
    segs[9] = '{1'b0, 1'b1, 10, 1'b1, 0, 1, 0};

    for (int i = 0; i < 10; i++) begin
      rst  = segs[i].rst;
      sw_i = segs[i].sw;
      n_press = 0; n_rel = 0; n_long = 0;
      repeat (segs[i].cycles) step();
      check($sformatf("seg%0d_sw_o", i), sw_o, segs[i].exp_sw_o);
      check_int($sformatf("seg%0d_press", i), n_press, segs[i].exp_press);
      check_int($sformatf("seg%0d_release", i), n_rel, segs[i].exp_rel);
      check_int($sformatf("seg%0d_long", i), n_long, segs[i].exp_long);
    end

    // Press / release edge timing relative to first sampling edge.
    do_reset();
    sw_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("press_edge%0d", k), press_o, (k == 6));
      check($sformatf("press_lvl_edge%0d", k), sw_o, (k < 6));
    end
    sw_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("release_edge%0d", k), release_o, (k == 6));
    end

    // Reset at edge 4 of a press debounce, switch still held afterwards.
    do_reset();
    sw_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("abort_no_press", press_o, 1'b0);
    end
    rst = 1'b1;
    repeat (2) begin
      step();
      check("abort_rst_press", press_o, 1'b0);
      check("abort_rst_lvl", sw_o, 1'b1);
    end
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("rebounce_edge%0d", k), press_o, (k == 6));
    end
    sw_i = 1'b1;
    repeat (10) step();

    // Long press: one pulse LC cycles after the press strobe (edge 6 + 16).
    do_reset();
    sw_i = 1'b0;
    first_long = -1;
    n_long = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (long_o === 1'b1 && first_long < 0) first_long = k;
    end
    check_int("long_count", n_long, (LONG_EN ? 1 : 0));
    check_int("long_edge", first_long, (LONG_EN ? 22 : -1));
    sw_i = 1'b1;
    repeat (10) step();

    // Randomized holds, occasional reset, checked against the model every cycle.
    do_reset();
    for (int it = 0; it < 70; it++) begin
      int hold;
      sw_i = 1'($urandom_range(0, 1));
      rst  = ($urandom_range(0, 19) == 0);
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 30) : $urandom_range(1, 7);
      repeat (hold) step();
      rst = 1'b0;
    end
    sw_i = 1'b1;
    repeat (12) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
